mem_access_unit: RTL and testbench

- Sits between the MEM pipeline stage and the word-wide data memory (`readData`/`address`/`writeData`/`memRead`/`memWrite`).
- Accepts byte, halfword and word load/store requests (lb/lbu/lh/lhu/lw/sb/sh/sw).
- Drives word-aligned accesses; sub-word stores are done as a read-modify-write sequence.
- Returns sign- or zero-extended load data and flags misaligned or out-of-range accesses. These never touch memory.

---
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response handshake and word-wide data-memory bus of the memory access unit.
// The master side is the pipeline plus data memory; the slave side is the unit itself.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] load_data;
   logic [31:0] address;
   logic [31:0] writeData;
   logic        memRead;
   logic        memWrite;
   logic [31:0] readData;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, readData,
      input  req_ready, resp_valid, resp_err, load_data, address, writeData, memRead, memWrite
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, readData,
      output req_ready, resp_valid, resp_err, load_data, address, writeData, memRead, memWrite
   );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit in front of a word-wide data memory.
// Sub-word stores use read-modify-write; bad requests are answered without touching memory.
module mem_access_unit #(
   parameter int MEM_WORDS = 8192
) (
   input logic              clk,
   input logic              reset,
   mem_access_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   localparam logic [31:0] MEM_WORDS_U = MEM_WORDS;

   state_t      state;
   state_t      next_state;
   logic        accept;
   logic        req_err;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [1:0]  lat_size;
   logic        lat_signed;
   logic        lat_write;
   logic        err_r;
   logic [31:0] load_r;
   logic [31:0] address_r;
   logic [31:0] wdata_r;
   logic [31:0] lane;
   logic [31:0] ext_data;
   logic [31:0] merged;

   assign accept = bus.req_valid && (state == IDLE);

   always_comb begin
      req_err = 1'b0;
      if (bus.req_size == 2'b11)
         req_err = 1'b1;
      if ((bus.req_size == 2'b01) && bus.req_addr[0])
         req_err = 1'b1;
      if ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
         req_err = 1'b1;
      if ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS_U)
         req_err = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Word stores skip the read; every other legal access reads first.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_err)
                  next_state = RESP;
               else if (bus.req_write && (bus.req_size == 2'b10))
                  next_state = WR;
               else
                  next_state = RD;
            end
         end
         RD:      next_state = lat_write ? WR : RESP;
         WR:      next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      lane     = bus.readData >> {lat_addr[1:0], 3'b000};
      ext_data = bus.readData;
      case (lat_size)
         2'b00:   ext_data = lat_signed ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
         2'b01:   ext_data = lat_signed ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
         default: ext_data = bus.readData;
      endcase
      merged = bus.readData;
      if (lat_size == 2'b00)
         merged[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
      else
         merged[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
   end

   // The memory address only moves for accesses that will reach memory.
   always_ff @(posedge clk) begin
      if (reset) begin
         lat_addr   <= 32'h0;
         lat_wdata  <= 32'h0;
         lat_size   <= 2'b00;
         lat_signed <= 1'b0;
         lat_write  <= 1'b0;
         err_r      <= 1'b0;
         load_r     <= 32'h0;
         address_r  <= 32'h0;
         wdata_r    <= 32'h0;
      end else begin
         if (accept) begin
            lat_addr   <= bus.req_addr;
            lat_wdata  <= bus.req_wdata;
            lat_size   <= bus.req_size;
            lat_signed <= bus.req_signed;
            lat_write  <= bus.req_write;
            err_r      <= req_err;
            load_r     <= 32'h0;
            if (!req_err) begin
               address_r <= {bus.req_addr[31:2], 2'b00};
               if (bus.req_write && (bus.req_size == 2'b10))
                  wdata_r <= bus.req_wdata;
            end
         end
         if (state == RD) begin
            if (lat_write)
               wdata_r <= merged;
            else
               load_r <= ext_data;
         end
      end
   end

   always_comb begin
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_err   = 1'b0;
      bus.load_data  = 32'h0;
      bus.memRead    = 1'b0;
      bus.memWrite   = 1'b0;
      case (state)
         IDLE: bus.req_ready = 1'b1;
         RD:   bus.memRead   = 1'b1;
         WR:   bus.memWrite  = 1'b1;
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_err   = err_r;
            bus.load_data  = load_r;
         end
         default: ;
      endcase
   end

   assign bus.address   = address_r;
   assign bus.writeData = wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural word memory attached.
// Stimulus pushes expected responses; a negedge monitor pops and compares them.
module tb_mem_access_unit;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          lat;
      string       name;
   } exp_t;

   logic clk;
   logic reset;

   mem_access_unit_if bus ();

   mem_access_unit #(.MEM_WORDS(8192)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] mem [0:8191];
   exp_t        expQ [$];
   int          accQ [$];
   int          checks;
   int          errors;
   int          cycle;
   int          rdCycles;
   int          wrCycles;
   int          accCount;
   logic [31:0] lastWrAddr;
   logic [31:0] lastWrData;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural data memory: combinational read, write on the rising edge.
   assign bus.readData = mem[bus.address[14:2]];
   always @(posedge clk) begin
      if (bus.memWrite)
         mem[bus.address[14:2]] <= bus.writeData;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   acc;
      cycle++;
      checkOutput("rd_wr_exclusive", {31'h0, bus.memRead & bus.memWrite}, 32'h0);
      if (reset) begin
         accQ.delete();
      end else begin
         if (bus.memRead)
            rdCycles++;
         if (bus.memWrite) begin
            wrCycles++;
            lastWrAddr = bus.address;
            lastWrData = bus.writeData;
         end
         if (bus.req_valid && bus.req_ready) begin
            accQ.push_back(cycle);
            accCount++;
         end
         if (bus.resp_valid) begin
            if ((expQ.size() == 0) || (accQ.size() == 0)) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
               e   = expQ.pop_front();
               acc = accQ.pop_front();
               checkOutput({e.name, " err"}, {31'h0, bus.resp_err}, {31'h0, e.err});
               checkOutput({e.name, " data"}, bus.load_data, e.data);
               checkOutput({e.name, " latency"}, cycle - acc, e.lat);
            end
         end
      end
   end

   // Called just after a rising edge; holds req_valid until the unit accepts.
   task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic expErr, input logic [31:0] expData, input int expLat,
                                input string name, input bit keep);
      exp_t e;
      int   n;
      bit   accepted;
      e.err  = expErr;
      e.data = expData;
      e.lat  = expLat;
      e.name = name;
      expQ.push_back(e);
      bus.req_write  = wr;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_valid  = 1'b1;
      n        = 0;
      accepted = 1'b0;
      while (!accepted && (n < 50)) begin
         @(negedge clk);
         if (bus.req_ready)
            accepted = 1'b1;
         n++;
      end
      @(posedge clk);
      #2;
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s accept: got no accept expected accept within 50 cycles", name);
         void'(expQ.pop_back());
      end
      if (!keep)
         bus.req_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((expQ.size() != 0) && (n < 50)) begin
         @(posedge clk);
         n++;
      end
      #2;
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: got %0d pending responses expected 0", expQ.size());
         expQ.delete();
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rdB;
      int wrB;
      int accB;
      checks = 0;
      errors = 0;
      cycle = 0;
      rdCycles = 0;
      wrCycles = 0;
      accCount = 0;
      lastWrAddr = 32'h0;
      lastWrData = 32'h0;
      reset = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_size = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr = 32'h0;
      bus.req_wdata = 32'h0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset req_ready", {31'h0, bus.req_ready}, 32'h1);
      checkOutput("reset resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      checkOutput("reset resp_err", {31'h0, bus.resp_err}, 32'h0);
      checkOutput("reset load_data", bus.load_data, 32'h0);
      checkOutput("reset address", bus.address, 32'h0);
      checkOutput("reset writeData", bus.writeData, 32'h0);
      checkOutput("reset memRead", {31'h0, bus.memRead}, 32'h0);
      checkOutput("reset memWrite", {31'h0, bus.memWrite}, 32'h0);
      @(posedge clk);
      #2;
      reset = 1'b0;

      wrB = wrCycles;
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, "sw 0x10", 1'b0);
      waitDrain();
      checkOutput("sw 0x10 write count", wrCycles - wrB, 1);
      checkOutput("sw 0x10 wr address", lastWrAddr, 32'h10);
      checkOutput("sw 0x10 wr data", lastWrData, 32'hDEADBEEF);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, "lw 0x10", 1'b0);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'h0, 2, "sw 0x20", 1'b0);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h30, 32'h80017FFF, 1'b0, 32'h0, 2, "sw 0x30", 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 1'b0, 32'h0, 3, "sb 0x21", 1'b0);
      waitDrain();
      checkOutput("sb 0x21 wr address", lastWrAddr, 32'h20);
      checkOutput("sb 0x21 wr data", lastWrData, 32'h1122AA44);
      checkOutput("sb 0x21 mem word", mem[8], 32'h1122AA44);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b0, 32'h000000AA, 2, "lbu 0x21", 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b0, 32'hFFFFFFAA, 2, "lb 0x21", 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 1'b0, 32'h00000022, 2, "lb 0x22", 1'b0);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 1'b0, 32'hFFFF8001, 2, "lh 0x32", 1'b0);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1'b0, 32'h00008001, 2, "lhu 0x32", 1'b0);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 1'b0, 32'h00007FFF, 2, "lh 0x30", 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h32, 32'hFFFF1234, 1'b0, 32'h0, 3, "sh 0x32", 1'b0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 32'h12347FFF, 2, "lw 0x30", 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h33, 32'h00000055, 1'b0, 32'h0, 3, "sb 0x33", 1'b0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 32'h55347FFF, 2, "lw 0x30 after sb", 1'b0);
      waitDrain();

      rdB = rdCycles;
      wrB = wrCycles;
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1, "lw 0x13 misaligned", 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h31, 32'hFFFF, 1'b1, 32'h0, 1, "sh 0x31 misaligned", 1'b0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h8000, 32'h0, 1'b1, 32'h0, 1, "lw 0x8000 range", 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h8003, 32'h0, 1'b1, 32'h0, 1, "lb 0x8003 range", 1'b0);
      applyStimulus(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 1, "size 11", 1'b0);
      waitDrain();
      checkOutput("errors memRead count", rdCycles - rdB, 0);
      checkOutput("errors memWrite count", wrCycles - wrB, 0);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h7FFC, 32'hCAFEF00D, 1'b0, 32'h0, 2, "sw 0x7FFC", 1'b0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h7FFC, 32'h0, 1'b0, 32'hCAFEF00D, 2, "lw 0x7FFC", 1'b0);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h40, 32'h55667788, 1'b0, 32'h0, 2, "sw 0x40", 1'b0);
      waitDrain();
      wrB = wrCycles;
      bus.req_write = 1'b1;
      bus.req_size = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr = 32'h41;
      bus.req_wdata = 32'h000000EE;
      bus.req_valid = 1'b1;
      @(negedge clk);
      checkOutput("rmw abort ready", {31'h0, bus.req_ready}, 32'h1);
      @(posedge clk);
      #2;
      reset = 1'b1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rmw abort req_ready", {31'h0, bus.req_ready}, 32'h1);
      checkOutput("rmw abort memRead", {31'h0, bus.memRead}, 32'h0);
      checkOutput("rmw abort memWrite", {31'h0, bus.memWrite}, 32'h0);
      repeat (3) @(posedge clk);
      #2;
      checkOutput("rmw abort write count", wrCycles - wrB, 0);
      checkOutput("rmw abort mem word", mem[16], 32'h55667788);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 32'h55667788, 2, "lw 0x40 after abort", 1'b0);
      waitDrain();

      accB = accCount;
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h50, 32'h01020304, 1'b0, 32'h0, 2, "burst sw 0x50", 1'b1);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b0, 32'h01020304, 2, "burst lw 0x50", 1'b1);
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h52, 32'h00000099, 1'b0, 32'h0, 3, "burst sb 0x52", 1'b1);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b0, 32'h01990304, 2, "burst lw 0x50 b", 1'b1);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1, "burst lw 0x13", 1'b1);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h52, 32'h0, 1'b0, 32'h00000199, 2, "burst lhu 0x52", 1'b0);
      waitDrain();
      checkOutput("burst accept count", accCount - accB, 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
